register_status_file: RTL and testbench

Architectural register file plus rename-status table that consumes the ROB's CDB commit broadcast. Holds 32×32-bit registers (x0 hardwired zero), a per-register busy bit and 4-bit producer tag, and a tag→rd map written at issue. Provides two combinational operand read ports with same-cycle CDB bypass to the issue stage and reservation station / LSB allocation. Sits between decode/issue and the ROB.

---
 rtl/register_status_file_if.sv | 26 ++
 rtl/register_status_file.sv | 63 ++++++
 tb/tb_register_status_file.sv | 130 +++++++++++++
 3 files changed

// File: rtl/register_status_file_if.sv
// register_status_file_if: issue, operand-read, CDB and flush signals between issue logic and the status file.
interface register_status_file_if;
   logic        rdy_in;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_tag;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_val, rs2_val;
   logic        rs1_busy, rs2_busy;
   logic [3:0]  rs1_tag, rs2_tag;
   logic        cdb_active;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic [31:0] cdb_addr;
   logic        predict_fail;
   modport master (
      output rdy_in, issue_valid, issue_rd, issue_tag, rs1_addr, rs2_addr,
             cdb_active, cdb_tag, cdb_val, cdb_addr, predict_fail,
      input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
   );
   modport slave (
      input  rdy_in, issue_valid, issue_rd, issue_tag, rs1_addr, rs2_addr,
             cdb_active, cdb_tag, cdb_val, cdb_addr, predict_fail,
      output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
   );
endinterface

// File: rtl/register_status_file.sv
// register_status_file: architectural registers plus rename busy/tag status, retired via the ROB commit broadcast,
// with two combinational operand ports that bypass the committing value.
module register_status_file (
   input logic clk_in,
   input logic rst_in,
   register_status_file_if.slave bus
);
   localparam int REG_NUM = 32;
   localparam int TAG_W = 4;
   logic [31:0]      regs [REG_NUM];
   logic [3:0]       tag [REG_NUM];
   logic [4:0]       map_rd [2**TAG_W];
   logic [REG_NUM-1:0] busy;
   logic [2**TAG_W-1:0] map_vld;
   logic [4:0]       commit_rd;
   logic             commit;
   logic             unused_debug;
   assign commit_rd = map_rd[bus.cdb_tag];
   assign commit = bus.cdb_active && map_vld[bus.cdb_tag];
   assign unused_debug = ^bus.cdb_addr;
   // Later assignments win, so issue overrides commit on busy/tag/map and flush overrides both.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         regs <= '{default: '0};
         tag <= '{default: '0};
         map_rd <= '{default: '0};
         busy <= '0;
         map_vld <= '0;
      end else if (bus.rdy_in) begin
         if (commit) begin
            map_vld[bus.cdb_tag] <= 1'b0;
            if (commit_rd != 5'd0) begin
               regs[commit_rd] <= bus.cdb_val;
               if (tag[commit_rd] == bus.cdb_tag) busy[commit_rd] <= 1'b0;
            end
         end
         if (bus.predict_fail) begin
            busy <= '0;
            tag <= '{default: '0};
            map_vld <= '0;
         end else if (bus.issue_valid) begin
            map_rd[bus.issue_tag] <= bus.issue_rd;
            map_vld[bus.issue_tag] <= 1'b1;
            if (bus.issue_rd != 5'd0) begin
               busy[bus.issue_rd] <= 1'b1;
               tag[bus.issue_rd] <= bus.issue_tag;
            end
         end
      end
   end
   // Returns {busy, tag, value} for one operand port.
   function automatic logic [36:0] rd_port(input logic [4:0] a, input logic ca,
                                           input logic [3:0] ct, input logic [31:0] cv);
      return (a == 5'd0) ? 37'd0 :
             !busy[a] ? {5'd0, regs[a]} :
             (ca && ct == tag[a]) ? {5'd0, cv} :
             {1'b1, tag[a], 32'd0};
   endfunction
   always_comb begin
      {bus.rs1_busy, bus.rs1_tag, bus.rs1_val} = rd_port(bus.rs1_addr, bus.cdb_active, bus.cdb_tag, bus.cdb_val);
      {bus.rs2_busy, bus.rs2_tag, bus.rs2_val} = rd_port(bus.rs2_addr, bus.cdb_active, bus.cdb_tag, bus.cdb_val);
   end
endmodule

// File: tb/tb_register_status_file.sv
// tb_register_status_file: table-driven vectors with an expected-read scoreboard, plus a mid-run reset sequence.
module tb_register_status_file;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   register_status_file_if bus ();
   register_status_file dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
   always #5 clk_in = ~clk_in;
   typedef struct {
      logic [31:0] v1; logic b1; logic [3:0] t1;
      logic [31:0] v2; logic b2; logic [3:0] t2;
   } exp_t;
   typedef struct {
      logic rdy, iv; logic [4:0] ird; logic [3:0] itag;
      logic [4:0] r1, r2;
      logic ca; logic [3:0] ct; logic [31:0] cv; logic pf;
      exp_t e;
   } vec_t;
   vec_t tbl[$];
   exp_t exp_q[$];
   int checks = 0, passes = 0;
   function automatic vec_t mk(logic rdy, logic iv, logic [4:0] ird, logic [3:0] itag,
                               logic [4:0] r1, logic [4:0] r2, logic ca, logic [3:0] ct,
                               logic [31:0] cv, logic pf,
                               logic [31:0] v1, logic b1, logic [3:0] t1,
                               logic [31:0] v2, logic b2, logic [3:0] t2);
      vec_t x;
      x.rdy = rdy; x.iv = iv; x.ird = ird; x.itag = itag; x.r1 = r1; x.r2 = r2;
      x.ca = ca; x.ct = ct; x.cv = cv; x.pf = pf;
      x.e = '{v1, b1, t1, v2, b2, t2};
      return x;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act === want) passes++;
      else $display("FAIL %s: got %h want %h", nm, act, want);
   endtask
   task automatic drive(vec_t x);
      bus.rdy_in = x.rdy; bus.issue_valid = x.iv; bus.issue_rd = x.ird; bus.issue_tag = x.itag;
      bus.rs1_addr = x.r1; bus.rs2_addr = x.r2; bus.cdb_active = x.ca; bus.cdb_tag = x.ct;
      bus.cdb_val = x.cv; bus.cdb_addr = 32'h1000 + {27'd0, x.ird}; bus.predict_fail = x.pf;
      exp_q.push_back(x.e);
   endtask
   task automatic compare(string nm);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         $display("FAIL %s: scoreboard empty", nm);
         return;
      end
      e = exp_q.pop_front();
      chk({nm, ".rs1_val"}, bus.rs1_val, e.v1);
      chk({nm, ".rs1_busy"}, {31'd0, bus.rs1_busy}, {31'd0, e.b1});
      chk({nm, ".rs1_tag"}, {28'd0, bus.rs1_tag}, {28'd0, e.t1});
      chk({nm, ".rs2_val"}, bus.rs2_val, e.v2);
      chk({nm, ".rs2_busy"}, {31'd0, bus.rs2_busy}, {31'd0, e.b2});
      chk({nm, ".rs2_tag"}, {28'd0, bus.rs2_tag}, {28'd0, e.t2});
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      //          rdy iv ird itag r1  r2  ca ct  cv            pf   v1            b1 t1  v2            b2 t2
      tbl.push_back(mk(1, 0, 0,  0,  5,  0,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 3,  7,  3,  3,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  3,  0,  0, 0,  0,            0,   0,            1, 7,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  3,  3,  1, 7,  32'hDEADBEEF, 0,   32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  3,  3,  1, 7,  32'h1234,     0,   32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  3,  0,  0, 0,  0,            0,   32'hDEADBEEF, 0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 4,  1,  4,  0,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 4,  2,  4,  0,  0, 0,  0,            0,   0,            1, 1,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  4,  0,  1, 1,  32'h11,       0,   0,            1, 2,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  4,  0,  0, 0,  0,            0,   0,            1, 2,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  4,  0,  1, 2,  32'h22,       0,   32'h22,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  4,  0,  0, 0,  0,            0,   32'h22,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 0,  5,  0,  3,  0, 0,  0,            0,   0,            0, 0,  32'hDEADBEEF, 0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  0,  4,  1, 5,  32'h99,       0,   0,            0, 0,  32'h22,       0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  0,  3,  0, 0,  0,            0,   0,            0, 0,  32'hDEADBEEF, 0, 0));
      tbl.push_back(mk(1, 1, 8,  9,  8,  0,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  8,  0,  1, 9,  32'h88,       0,   32'h88,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 6,  3,  8,  0,  0, 0,  0,            0,   32'h88,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 8,  4,  6,  8,  0, 0,  0,            0,   0,            1, 3,  32'h88,       0, 0));
      tbl.push_back(mk(1, 1, 10, 6,  6,  8,  1, 3,  32'h55,       1,   32'h55,       0, 0,  0,            1, 4));
      tbl.push_back(mk(1, 0, 0,  0,  6,  8,  1, 4,  32'h77,       0,   32'h55,       0, 0,  32'h88,       0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  10, 8,  0, 0,  0,            0,   0,            0, 0,  32'h88,       0, 0));
      tbl.push_back(mk(1, 1, 12, 10, 12, 0,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 12, 11, 12, 0,  1, 10, 32'hAB,       0,   32'hAB,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 14, 11, 12, 0,  1, 11, 32'hCD,       0,   32'hCD,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  12, 14, 0, 0,  0,            0,   32'hCD,       0, 0,  0,            1, 11));
      tbl.push_back(mk(1, 0, 0,  0,  12, 14, 1, 11, 32'hEE,       0,   32'hCD,       0, 0,  32'hEE,       0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  12, 14, 0, 0,  0,            0,   32'hCD,       0, 0,  32'hEE,       0, 0));
      tbl.push_back(mk(0, 1, 9,  2,  9,  0,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  9,  0,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 1, 15, 0,  15, 0,  0, 0,  0,            0,   0,            0, 0,  0,            0, 0));
      tbl.push_back(mk(0, 0, 0,  0,  15, 0,  1, 0,  32'h42,       0,   32'h42,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  15, 0,  0, 0,  0,            0,   0,            1, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  15, 0,  1, 0,  32'h43,       0,   32'h43,       0, 0,  0,            0, 0));
      tbl.push_back(mk(1, 0, 0,  0,  15, 3,  0, 0,  0,            0,   32'h43,       0, 0,  32'hDEADBEEF, 0, 0));
      drive(mk(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk_in);
      compare("in_reset");
      rst_in = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk_in);
         drive(tbl[i]);
         #2;
         compare($sformatf("vec%0d", i));
      end
      // Mid-run reset: rd 20 goes busy, then an async reset pulse must clear everything immediately.
      @(negedge clk_in);
      drive(mk(1, 1, 20, 5, 20, 3, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0));
      #2 compare("pre_rst_issue");
      @(negedge clk_in);
      drive(mk(1, 0, 0, 0, 20, 15, 0, 0, 0, 0, 0, 1, 5, 32'h43, 0, 0));
      #2 compare("pre_rst_busy");
      rst_in = 1'b0;
      drive(mk(1, 0, 0, 0, 20, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1 compare("async_rst");
      @(negedge clk_in);
      rst_in = 1'b1;
      drive(mk(1, 0, 0, 0, 3, 6, 1, 7, 32'h5A5A, 0, 0, 0, 0, 0, 0, 0));
      #2 compare("post_rst_clear");
      @(negedge clk_in);
      drive(mk(1, 0, 0, 0, 3, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2 compare("post_rst_stale_commit");
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
